result_collector: RTL and testbench



---
 rtl/mm_pkg.sv | 16 +
 rtl/result_collector_if.sv | 24 ++
 rtl/result_collector.sv | 128 ++++++++++++
 tb/tb_result_collector.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared constants, index widths and collector state encoding for the
// matrix-multiply readout path.
package mm_pkg;
  localparam int PART_W = 8;
  localparam int NPARTS = 3;
  localparam int NRES   = 9;
  localparam int RES_W  = PART_W * NPARTS;
  localparam int RIDX_W = 4;
  localparam int PIDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } coll_state_e;
endpackage

// File: rtl/result_collector_if.sv
// Slice-stream input and valid/ready result output of the result collector.
interface result_collector_if #(
  parameter int PART_W = mm_pkg::PART_W,
  parameter int NPARTS = mm_pkg::NPARTS
);
  logic                      part_valid;
  logic [PART_W-1:0]         part_data;
  logic [mm_pkg::RIDX_W-1:0] res_idx;
  logic [mm_pkg::PIDX_W-1:0] part_idx;
  logic                      res_valid;
  logic                      res_ready;
  logic [PART_W*NPARTS-1:0]  res_data;
  logic [mm_pkg::RIDX_W-1:0] res_index;

  modport slave (
    input  part_valid, part_data, res_idx, part_idx, res_ready,
    output res_valid, res_data, res_index
  );

  modport master (
    output part_valid, part_data, res_idx, part_idx, res_ready,
    input  res_valid, res_data, res_index
  );
endinterface

// File: rtl/result_collector.sv
// Captures the 27-slice readout stream, checks ordering, reassembles the nine
// results into a local buffer and drains them in index order.
//   state      | meaning
//   ST_IDLE    | waiting for done; err holds its last value
//   ST_COLLECT | accepting slices in (rc, pc) order
//   ST_DRAIN   | presenting res_buf_q[dp] until each is accepted
module result_collector #(
  parameter int PART_W = mm_pkg::PART_W,
  parameter int NPARTS = mm_pkg::NPARTS,
  parameter int NRES   = mm_pkg::NRES,
  parameter int RES_W  = PART_W * NPARTS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  result_collector_if.slave bus,
  output logic              busy,
  output logic              err,
  output logic              all_done
);
  import mm_pkg::*;

  localparam logic [PIDX_W-1:0] LAST_PART = PIDX_W'(NPARTS - 1);
  localparam logic [RIDX_W-1:0] LAST_RES  = RIDX_W'(NRES - 1);

  coll_state_e       state_q, state_d;
  logic [PIDX_W-1:0] pc_q, pc_d;
  logic [RIDX_W-1:0] rc_q, rc_d;
  logic [RIDX_W-1:0] dp_q, dp_d;
  logic [RES_W-1:0]  asm_q, asm_d;
  logic [RES_W-1:0]  res_buf_q [NRES];
  logic [RES_W-1:0]  res_buf_d [NRES];
  logic              err_q, err_d;
  logic              all_done_q, all_done_d;
  logic [RES_W-1:0]  merged;
  logic              slice_ok;

  assign slice_ok = (bus.res_idx == rc_q) && (bus.part_idx == pc_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rc_d       = rc_q;
    dp_d       = dp_q;
    asm_d      = asm_q;
    err_d      = err_q;
    all_done_d = 1'b0;
    res_buf_d  = res_buf_q;
    // Assembly register with the incoming slice already folded in, so the
    // last slice lands in the buffer on the same edge it arrives.
    merged = asm_q;
    merged[PART_W*pc_q +: PART_W] = bus.part_data;

    unique case (state_q)
      ST_IDLE: begin
        if (done) begin
          state_d = ST_COLLECT;
          err_d   = 1'b0;
          pc_d    = '0;
          rc_d    = '0;
        end
      end
      ST_COLLECT: begin
        if (bus.part_valid) begin
          if (slice_ok) begin
            asm_d = merged;
            if (pc_q == LAST_PART) begin
              res_buf_d[rc_q] = merged;
              pc_d = '0;
              rc_d = rc_q + RIDX_W'(1);
              if (rc_q == LAST_RES) begin
                state_d = ST_DRAIN;
                rc_d    = '0;
                dp_d    = '0;
              end
            end else begin
              pc_d = pc_q + PIDX_W'(1);
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.res_ready) begin
          if (dp_q == LAST_RES) begin
            state_d    = ST_IDLE;
            dp_d       = '0;
            all_done_d = 1'b1;
          end else begin
            dp_d = dp_q + RIDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      rc_q       <= '0;
      dp_q       <= '0;
      asm_q      <= '0;
      err_q      <= 1'b0;
      all_done_q <= 1'b0;
      for (int i = 0; i < NRES; i++) res_buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rc_q       <= rc_d;
      dp_q       <= dp_d;
      asm_q      <= asm_d;
      err_q      <= err_d;
      all_done_q <= all_done_d;
      res_buf_q  <= res_buf_d;
    end
  end

  assign bus.res_valid = (state_q == ST_DRAIN);
  assign bus.res_data  = bus.res_valid ? res_buf_q[dp_q] : '0;
  assign bus.res_index = bus.res_valid ? dp_q : '0;
  assign busy          = (state_q != ST_IDLE);
  assign err           = err_q;
  assign all_done      = all_done_q;
endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: table of drain scenarios with a
// result scoreboard, plus hand-written reset and ordering-error sequences.
module tb_result_collector;
  import mm_pkg::*;

  typedef struct {
    int gap_max;    // max idle cycles inserted before each slice
    int ready_pct;  // probability (%) res_ready is high in a cycle
    bit spurious;   // pulse done after slice 10
    int abort_at;   // assert reset after this many accepted results (-1 none)
    int exp_lat;    // expected done->all_done cycles (0 = not checked)
  } vec_t;

  typedef struct {
    logic [RIDX_W-1:0] idx;
    logic [RES_W-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic done = 1'b0;
  logic busy, err, all_done;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t expq[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  result_collector_if bus ();

  result_collector dut (
    .clk(clk), .rst(rst), .done(done), .bus(bus),
    .busy(busy), .err(err), .all_done(all_done)
  );

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [RES_W-1:0] res_val(input int k);
    logic [31:0] v;
    v = (k + 1) * 32'h0001_0203;
    return v[RES_W-1:0];
  endfunction

  task automatic drive_slices(input int gap_max, input bit spurious);
    for (int s = 0; s < NRES * NPARTS; s++) begin
      int k;
      int p;
      int gap;
      logic [RES_W-1:0] w;
      k = s / NPARTS;
      p = s % NPARTS;
      w = res_val(k);
      gap = $urandom_range(0, gap_max);
      repeat (gap) begin @(posedge clk); #1; end
      bus.part_valid = 1'b1;
      bus.res_idx    = RIDX_W'(k);
      bus.part_idx   = PIDX_W'(p);
      bus.part_data  = w[PART_W*p +: PART_W];
      if (p == NPARTS - 1) expq.push_back('{RIDX_W'(k), w});
      @(posedge clk); #1;
      bus.part_valid = 1'b0;
      if (spurious && s == 10) begin
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
      end
    end
  endtask

  task automatic monitor(input vec_t v, input time t0);
    int   cyc = 0;
    int   got = 0;
    int   lat;
    bit   fin = 0;
    bit   stalled = 0;
    bit   ad;
    exp_t e;
    logic [RES_W-1:0]  hd = '0;
    logic [RIDX_W-1:0] hi = '0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        chk(1'b0, "drain_timeout", got, NRES);
        fin = 1;
      end else if (v.abort_at >= 0 && got == v.abort_at) begin
        rst = 1'b0;
        #1;
        chk({bus.res_valid, busy, err, all_done} == 4'b0 && bus.res_data == '0 && bus.res_index == '0,
            "abort_outputs_zero", {bus.res_valid, busy, err, all_done, bus.res_index, bus.res_data}, 0);
        ad = 0;
        repeat (3) begin @(negedge clk); ad |= all_done; end
        chk(!ad, "abort_no_all_done", ad, 0);
        rst = 1'b1;
        expq.delete();
        fin = 1;
      end else begin
        if (stalled)
          chk(bus.res_valid && bus.res_data == hd && bus.res_index == hi, "stall_hold",
              {bus.res_index, bus.res_data}, {hi, hd});
        stalled = 0;
        if (all_done) begin
          chk(got == NRES, "accept_count", got, NRES);
          if (v.exp_lat > 0) begin
            lat = int'(($time - 5 - t0) / 10) + 1;
            chk(lat == v.exp_lat, "done_to_all_done", lat, v.exp_lat);
          end
          fin = 1;
        end else begin
          bus.res_ready = ($urandom_range(0, 99) < v.ready_pct);
          if (bus.res_valid && bus.res_ready) begin
            if (expq.size() == 0) begin
              chk(1'b0, "extra_result", {bus.res_index, bus.res_data}, 0);
            end else begin
              e = expq.pop_front();
              chk(bus.res_data == e.data && bus.res_index == e.idx, "result",
                  {bus.res_index, bus.res_data}, {e.idx, e.data});
            end
            got++;
          end else if (bus.res_valid) begin
            stalled = 1;
            hd = bus.res_data;
            hi = bus.res_index;
          end
        end
      end
    end
  endtask

  task automatic run(input vec_t v);
    time t0;
    expq.delete();
    done = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1;
    done = 1'b0;
    chk(busy && !err, "arm_busy_err_clear", {busy, err}, 2'b10);
    fork
      drive_slices(v.gap_max, v.spurious);
      monitor(v, t0);
    join
    @(negedge clk);
    chk(!err && !busy && !bus.res_valid, "run_end_idle", {err, busy, bus.res_valid}, 0);
  endtask

  initial begin
    int vseen;
    vecs[0] = '{0, 100, 0, -1, 37};  // nominal
    vecs[1] = '{3, 100, 0, -1, 0};   // gapped input
    vecs[2] = '{0, 50,  0, -1, 0};   // backpressure
    vecs[3] = '{2, 40,  0,  4, 0};   // reset mid-drain
    vecs[4] = '{0, 100, 0, -1, 37};  // fresh nominal after reset
    vecs[5] = '{0, 100, 1, -1, 0};   // spurious done mid-collect
    vecs[6] = '{2, 60,  0, -1, 0};   // gaps plus backpressure

    bus.part_valid = 1'b0;
    bus.part_data  = '0;
    bus.res_idx    = '0;
    bus.part_idx   = '0;
    bus.res_ready  = 1'b1;

    repeat (2) @(negedge clk);
    chk({bus.res_valid, busy, err, all_done} == 4'b0 && bus.res_data == '0 && bus.res_index == '0,
        "reset_state", {bus.res_valid, busy, err, all_done, bus.res_index, bus.res_data}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Slice in IDLE is ignored, then an out-of-order first slice sets err.
    bus.part_valid = 1'b1; bus.res_idx = 4'd1; bus.part_idx = 2'd0; bus.part_data = 8'hAA;
    @(posedge clk); #1;
    bus.part_valid = 1'b0;
    chk(!err && !busy, "idle_slice_ignored", {err, busy}, 0);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    chk(busy, "err_seq_arm", busy, 1);
    bus.part_valid = 1'b1; bus.res_idx = 4'd1; bus.part_idx = 2'd0;
    @(posedge clk); #1;
    bus.part_valid = 1'b0;
    chk(err && !busy, "order_err_set", {err, busy}, 2'b10);
    vseen = 0;
    repeat (6) begin @(negedge clk); if (bus.res_valid) vseen++; end
    chk(vseen == 0, "order_err_no_valid", vseen, 0);
    chk(err, "order_err_sticky", err, 1);

    for (int i = 0; i < 7; i++) run(vecs[i]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
